nios_ii_onchip_mem_loader: RTL and testbench



---
 rtl/nios_ii_onchip_mem_loader_pkg.sv | 32 +++
 rtl/nios_ii_onchip_mem_loader_if.sv | 53 +++++
 rtl/nios_ii_onchip_mem_loader_packer.sv | 56 +++++
 rtl/nios_ii_onchip_mem_loader.sv | 145 ++++++++++++++
 tb/tb_nios_ii_onchip_mem_loader.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_ii_onchip_mem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nios_ii_mem_loader_pkg                                       |
// | Description : Shared types and constants for the on-chip memory loader.    |
// |               Holds the FSM state encoding, the lane count of a memory     |
// |               word and a helper that turns a filled-lane count into a      |
// |               byteenable mask.                                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package nios_ii_mem_loader_pkg;

  // Byte lanes per 32-bit memory word.
  localparam int LANES = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2
  } state_t;

  // Lanes 0..filled-1 are enabled; lanes are always filled from lane 0 upward.
  function automatic logic [LANES-1:0] lane_mask(input logic [2:0] filled);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      if (int'(filled) > i) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_ii_onchip_mem_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nios_ii_onchip_mem_loader_if                                 |
// | Description : Bundles the Avalon-ST byte sink, the on-chip RAM write port  |
// |               and the loader status outputs.                               |
// |   slave  : loader side (sinks the stream, drives RAM port and status)      |
// |   master : environment side (sources the stream, observes RAM and status)  |
// |   in_data/in_valid/in_startofpacket/in_endofpacket -> loader, in_ready <-  |
// |   mem_address/byteenable/chipselect/write/writedata/clken/reset_req <-     |
// |   busy/done/overflow/word_count <-                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface nios_ii_onchip_mem_loader_if
  import nios_ii_mem_loader_pkg::*;
#(
  parameter int ADDR_W = 13
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_startofpacket;
  logic               in_endofpacket;
  logic               in_ready;

  logic [ADDR_W-1:0]  mem_address;
  logic [LANES-1:0]   mem_byteenable;
  logic               mem_chipselect;
  logic               mem_write;
  logic [8*LANES-1:0] mem_writedata;
  logic               mem_clken;
  logic               mem_reset_req;

  logic               busy;
  logic               done;
  logic               overflow;
  logic [ADDR_W:0]    word_count;

  modport slave (
    input  in_data, in_valid, in_startofpacket, in_endofpacket,
    output in_ready,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken, mem_reset_req,
    output busy, done, overflow, word_count
  );

  modport master (
    output in_data, in_valid, in_startofpacket, in_endofpacket,
    input  in_ready,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken, mem_reset_req,
    input  busy, done, overflow, word_count
  );
endinterface
`default_nettype wire

// File: rtl/nios_ii_onchip_mem_loader_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nios_ii_mem_loader_packer                                    |
// | Description : Little-endian byte-to-word packer. Byte n of a word lands in |
// |               lane n. Outputs are forced to zero unless i_write_en is set. |
// |   i_data       : incoming byte                                             |
// |   i_load_first : start a new word with i_data in lane 0, others cleared    |
// |   i_push       : store i_data in the next free lane                        |
// |   i_clear      : empty all lanes (word has been written)                   |
// |   i_write_en   : drive writedata/byteenable for the current write cycle    |
// |   o_lane_count : number of lanes currently filled (0..4)                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nios_ii_mem_loader_packer
  import nios_ii_mem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         i_data,
  input  logic               i_load_first,
  input  logic               i_push,
  input  logic               i_clear,
  input  logic               i_write_en,
  output logic [8*LANES-1:0] o_writedata,
  output logic [LANES-1:0]   o_byteenable,
  output logic [2:0]         o_lane_count
);

  logic [2:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_count <= 3'd0;
    else if (i_clear)      r_count <= 3'd0;
    else if (i_load_first) r_count <= 3'd1;
    else if (i_push)       r_count <= r_count + 3'd1;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0] r_lane;

    // Clearing every lane between words keeps unfilled lanes at zero.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                             r_lane <= 8'h00;
      else if (i_clear)                         r_lane <= 8'h00;
      else if (i_load_first)                    r_lane <= (k == 0) ? i_data : 8'h00;
      else if (i_push && (r_count == 3'(k)))    r_lane <= i_data;
    end

    assign o_writedata[8*k +: 8] = i_write_en ? r_lane : 8'h00;
  end

  assign o_byteenable = i_write_en ? lane_mask(r_count) : '0;
  assign o_lane_count = r_count;

endmodule
`default_nettype wire

// File: rtl/nios_ii_onchip_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : nios_ii_onchip_mem_loader                                    |
// | Description : Loads an Avalon-ST byte packet into an on-chip RAM, packing  |
// |               4 bytes per word starting at BASE_ADDR. Bytes beyond the     |
// |               last RAM word are swallowed and flagged as overflow.         |
// |   clk, reset_n : clock, asynchronous active-low reset                      |
// |   bus (slave)  : stream sink, RAM write port and status outputs            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module nios_ii_onchip_mem_loader
  import nios_ii_mem_loader_pkg::*;
#(
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 8192,
  parameter int ADDR_W    = 13
) (
  input  logic                      clk,
  input  logic                      reset_n,
  nios_ii_onchip_mem_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] c_base_addr = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W:0]   r_word_count;
  logic              r_overflow;
  logic              r_discard;    // past the last RAM word, drop bytes until eop
  logic              r_eop;        // word being collected/written closes the packet
  logic              r_done;

  logic       w_ready, w_accept, w_write;
  logic       w_load_first, w_push, w_word_done, w_drop_end;
  logic [2:0] w_lane_count;

  assign w_ready  = (r_state != S_WRITE);
  assign w_accept = bus.in_valid & w_ready;
  assign w_write  = (r_state == S_WRITE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_load_first = 1'b0;
    w_push       = 1'b0;
    w_word_done  = 1'b0;
    w_drop_end   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept && bus.in_startofpacket) begin
          w_load_first = 1'b1;
          w_next       = bus.in_endofpacket ? S_WRITE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (w_accept) begin
          if (bus.in_startofpacket) begin
            // A fresh sop abandons the partial word and restarts the image.
            w_load_first = 1'b1;
            w_next       = bus.in_endofpacket ? S_WRITE : S_COLLECT;
          end else if (r_discard) begin
            if (bus.in_endofpacket) begin
              w_drop_end = 1'b1;
              w_next     = S_IDLE;
            end
          end else begin
            w_push = 1'b1;
            if ((w_lane_count == 3'd3) || bus.in_endofpacket) w_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        w_word_done = 1'b1;
        w_next      = r_eop ? S_IDLE : S_COLLECT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_address    <= c_base_addr;
      r_word_count <= '0;
      r_overflow   <= 1'b0;
      r_discard    <= 1'b0;
      r_eop        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (w_word_done & r_eop) | w_drop_end;
      if (w_load_first) begin
        r_address    <= c_base_addr;
        r_word_count <= '0;
        r_overflow   <= 1'b0;
        r_discard    <= 1'b0;
        r_eop        <= bus.in_endofpacket;
      end else if (w_push) begin
        r_eop <= bus.in_endofpacket;
      end
      if (w_word_done) begin
        r_word_count <= r_word_count + 1'b1;
        // The address parks on the last word so it never leaves the RAM.
        if (r_address == c_last_addr) begin
          if (!r_eop) begin
            r_overflow <= 1'b1;
            r_discard  <= 1'b1;
          end
        end else begin
          r_address <= r_address + 1'b1;
        end
      end
      if (w_drop_end) r_discard <= 1'b0;
    end
  end

  nios_ii_mem_loader_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_data       (bus.in_data),
    .i_load_first (w_load_first),
    .i_push       (w_push),
    .i_clear      (w_word_done),
    .i_write_en   (w_write),
    .o_writedata  (bus.mem_writedata),
    .o_byteenable (bus.mem_byteenable),
    .o_lane_count (w_lane_count)
  );

  assign bus.in_ready       = w_ready;
  assign bus.mem_address    = r_address;
  assign bus.mem_write      = w_write;
  assign bus.mem_chipselect = w_write;
  assign bus.mem_clken      = 1'b1;
  assign bus.mem_reset_req  = 1'b0;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.done           = r_done;
  assign bus.overflow       = r_overflow;
  assign bus.word_count     = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_nios_ii_onchip_mem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_nios_ii_onchip_mem_loader                                 |
// | Description : Self-checking bench for the on-chip memory loader. Drives a  |
// |               full-size instance and a 4-word instance from one stimulus   |
// |               source; sel chooses which one is handshaked and observed.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_nios_ii_onchip_mem_loader;

  typedef struct packed { logic [7:0] d; logic sop; logic eop; } byte_t;
  typedef struct packed { logic [12:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
  typedef struct {
    bit          sel;
    logic [7:0]  base;
    int          nbytes;
    int          exp_cycles;
    int          exp_nwr;
    logic [31:0] exp_first;
    logic [31:0] exp_last;
    logic [12:0] exp_last_addr;
    logic [3:0]  exp_last_be;
    int          exp_wc;
    bit          exp_ov;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
  bit sel = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;
  int done_cnt = 0;
  int m_done, m_wc;
  bit m_ov;
  byte_t stim[$];
  wr_t   obs_q[$];
  wr_t   exp_q[$];
  vec_t  vecs[8];

  nios_ii_onchip_mem_loader_if #(.ADDR_W(13)) ifa ();
  nios_ii_onchip_mem_loader_if #(.ADDR_W(2))  ifb ();

  assign ifa.in_data = s_data;  assign ifa.in_valid = s_valid;
  assign ifa.in_startofpacket = s_sop;  assign ifa.in_endofpacket = s_eop;
  assign ifb.in_data = s_data;  assign ifb.in_valid = s_valid;
  assign ifb.in_startofpacket = s_sop;  assign ifb.in_endofpacket = s_eop;

  nios_ii_onchip_mem_loader #(.BASE_ADDR(0), .DEPTH(8192), .ADDR_W(13)) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  nios_ii_onchip_mem_loader #(.BASE_ADDR(0), .DEPTH(4), .ADDR_W(2)) dut_small (
    .clk(clk), .reset_n(reset_n), .bus(ifb));

  logic        w_ready, w_write, w_cs, w_clken, w_rreq, w_busy, w_done, w_ov;
  logic [12:0] w_addr;
  logic [31:0] w_data;
  logic [3:0]  w_be;
  logic [13:0] w_wc;
  assign w_ready = sel ? ifb.in_ready       : ifa.in_ready;
  assign w_write = sel ? ifb.mem_write      : ifa.mem_write;
  assign w_cs    = sel ? ifb.mem_chipselect : ifa.mem_chipselect;
  assign w_clken = sel ? ifb.mem_clken      : ifa.mem_clken;
  assign w_rreq  = sel ? ifb.mem_reset_req  : ifa.mem_reset_req;
  assign w_busy  = sel ? ifb.busy           : ifa.busy;
  assign w_done  = sel ? ifb.done           : ifa.done;
  assign w_ov    = sel ? ifb.overflow       : ifa.overflow;
  assign w_addr  = sel ? {11'd0, ifb.mem_address} : ifa.mem_address;
  assign w_data  = sel ? ifb.mem_writedata  : ifa.mem_writedata;
  assign w_be    = sel ? ifb.mem_byteenable : ifa.mem_byteenable;
  assign w_wc    = sel ? {11'd0, ifb.word_count} : ifa.word_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (reset_n) begin
      check("ready_vs_write", 32'(w_ready), 32'(!w_write));
      check("chipselect", 32'(w_cs), 32'(w_write));
      check("clken", 32'(w_clken), 1);
      check("reset_req", 32'(w_rreq), 0);
      if (w_write) obs_q.push_back(wr_t'{w_addr, w_data, w_be});
      if (w_done) done_cnt++;
    end
  end

  task automatic check_reset_vals(input string p);
    check({p, "_ready"}, 32'(w_ready), 1);
    check({p, "_write"}, 32'(w_write), 0);
    check({p, "_cs"},    32'(w_cs), 0);
    check({p, "_be"},    32'(w_be), 0);
    check({p, "_data"},  w_data, 0);
    check({p, "_addr"},  32'(w_addr), 0);
    check({p, "_busy"},  32'(w_busy), 0);
    check({p, "_done"},  32'(w_done), 0);
    check({p, "_ov"},    32'(w_ov), 0);
    check({p, "_wc"},    32'(w_wc), 0);
  endtask

  task automatic apply_reset(input bit s);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_data = 8'h00;
    reset_n = 1'b0; sel = s;
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    obs_q.delete();
    done_cnt = 0;
  endtask

  // Returns one time unit after the edge that accepted the byte.
  task automatic send_byte(input byte_t b);
    int waitc;
    waitc = 0;
    s_data = b.d; s_sop = b.sop; s_eop = b.eop; s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (w_ready) break;
      waitc++;
      if (waitc > 20) begin
        check("ready_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic drive_stim(input bit gaps);
    foreach (stim[i]) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
      send_byte(stim[i]);
    end
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
  endtask

  task automatic drain();
    repeat (6) begin @(posedge clk); #1; end
  endtask

  // Packet-level reference: word k of a packet holds bytes 4k..4k+3 and goes
  // to address k; words at or beyond depth are never written.
  task automatic run_model(input int depth);
    logic [7:0]  pkt[$];
    bit          inpkt;
    int          k, n;
    logic [31:0] d;
    inpkt = 0; exp_q.delete(); m_done = 0; m_wc = 0; m_ov = 0;
    foreach (stim[i]) begin
      if (stim[i].sop) begin
        pkt.delete(); inpkt = 1; m_wc = 0; m_ov = 0;
      end
      if (inpkt) begin
        pkt.push_back(stim[i].d);
        if ((pkt.size() % 4 == 0) || stim[i].eop) begin
          k = (pkt.size() - 1) / 4;
          if (k < depth) begin
            n = pkt.size() - 4 * k;
            d = '0;
            for (int j = 0; j < n; j++) d[8*j +: 8] = pkt[4*k + j];
            exp_q.push_back(wr_t'{13'(k), d, 4'((1 << n) - 1)});
            m_wc = k + 1;
            if ((k == depth - 1) && !stim[i].eop) m_ov = 1;
          end
        end
        if (stim[i].eop) begin
          m_done++;
          inpkt = 0;
        end
      end
    end
  endtask

  task automatic run_random(input bit s, input int npk, input int maxlen);
    int len, a;
    apply_reset(s);
    stim.delete();
    for (int p = 0; p < npk; p++) begin
      if ($urandom_range(0, 3) == 0)
        stim.push_back(byte_t'{8'($urandom), 1'b0, 1'($urandom_range(0, 1))});
      if ($urandom_range(0, 4) == 0) begin
        a = $urandom_range(1, 3);
        for (int j = 0; j < a; j++) stim.push_back(byte_t'{8'($urandom), j == 0, 1'b0});
      end
      len = $urandom_range(1, maxlen);
      for (int j = 0; j < len; j++) stim.push_back(byte_t'{8'($urandom), j == 0, j == len - 1});
    end
    run_model(s ? 4 : 8192);
    drive_stim(1'b1);
    drain();
    check("rnd_nwr", obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check("rnd_addr", 32'(obs_q[i].addr), 32'(exp_q[i].addr));
      check("rnd_data", obs_q[i].data, exp_q[i].data);
      check("rnd_be",   32'(obs_q[i].be), 32'(exp_q[i].be));
    end
    check("rnd_done", done_cnt, m_done);
    check("rnd_wc",   32'(w_wc), m_wc);
    check("rnd_ov",   32'(w_ov), 32'(m_ov));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    longint t0;
    // sel, base, nbytes, cycles, nwr, first, last, last_addr, last_be, wc, ov
    vecs[0] = '{1'b0, 8'h11,  8,  9, 2, 32'h44332211, 32'h88776655, 13'd1, 4'hF, 2, 1'b0};
    vecs[1] = '{1'b0, 8'hAA,  5,  6, 2, 32'hDDCCBBAA, 32'h000000EE, 13'd1, 4'h1, 2, 1'b0};
    vecs[2] = '{1'b0, 8'h5A,  1,  1, 1, 32'h0000005A, 32'h0000005A, 13'd0, 4'h1, 1, 1'b0};
    vecs[3] = '{1'b0, 8'h01,  6,  7, 2, 32'h34231201, 32'h00005645, 13'd1, 4'h3, 2, 1'b0};
    vecs[4] = '{1'b0, 8'h10,  7,  8, 2, 32'h43322110, 32'h00766554, 13'd1, 4'h7, 2, 1'b0};
    vecs[5] = '{1'b0, 8'h21,  4,  4, 1, 32'h54433221, 32'h54433221, 13'd0, 4'hF, 1, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 20, 24, 4, 32'h33221100, 32'hFFEEDDCC, 13'd3, 4'hF, 4, 1'b1};
    vecs[7] = '{1'b1, 8'h00, 16, 19, 4, 32'h33221100, 32'hFFEEDDCC, 13'd3, 4'hF, 4, 1'b0};

    for (int v = 0; v < 8; v++) begin
      apply_reset(vecs[v].sel);
      stim.delete();
      for (int i = 0; i < vecs[v].nbytes; i++)
        stim.push_back(byte_t'{vecs[v].base + 8'(17 * i), i == 0, i == vecs[v].nbytes - 1});
      t0 = $time;
      drive_stim(1'b0);
      check("vec_cycles", 32'(($time - t0) / 10), vecs[v].exp_cycles);
      drain();
      check("vec_nwr", obs_q.size(), vecs[v].exp_nwr);
      if (obs_q.size() > 0) begin
        check("vec_first_data", obs_q[0].data, vecs[v].exp_first);
        check("vec_first_addr", 32'(obs_q[0].addr), 0);
        check("vec_last_data", obs_q[obs_q.size()-1].data, vecs[v].exp_last);
        check("vec_last_addr", 32'(obs_q[obs_q.size()-1].addr), 32'(vecs[v].exp_last_addr));
        check("vec_last_be", 32'(obs_q[obs_q.size()-1].be), 32'(vecs[v].exp_last_be));
      end
      check("vec_done", done_cnt, 1);
      check("vec_wc", 32'(w_wc), vecs[v].exp_wc);
      check("vec_ov", 32'(w_ov), 32'(vecs[v].exp_ov));
      check("vec_busy", 32'(w_busy), 0);
    end

    // Restart: a second sop drops the two-byte partial word.
    apply_reset(1'b0);
    send_byte(byte_t'{8'hA0, 1'b1, 1'b0});
    send_byte(byte_t'{8'hA1, 1'b0, 1'b0});
    send_byte(byte_t'{8'hB0, 1'b1, 1'b0});
    send_byte(byte_t'{8'hB1, 1'b0, 1'b0});
    send_byte(byte_t'{8'hB2, 1'b0, 1'b0});
    check("restart_no_early_write", 32'(w_write), 0);
    send_byte(byte_t'{8'hB3, 1'b0, 1'b1});
    check("restart_write_latency", 32'(w_write), 1);
    check("restart_ready_low", 32'(w_ready), 0);
    check("restart_addr", 32'(w_addr), 0);
    check("restart_be", 32'(w_be), 32'h0000000F);
    check("restart_data", w_data, 32'hB3B2B1B0);
    drain();
    check("restart_nwr", obs_q.size(), 1);
    check("restart_done", done_cnt, 1);
    check("restart_wc", 32'(w_wc), 1);

    // Reset mid-packet abandons the word; a stray byte after release is dropped.
    apply_reset(1'b0);
    send_byte(byte_t'{8'hC0, 1'b1, 1'b0});
    send_byte(byte_t'{8'hC1, 1'b0, 1'b0});
    send_byte(byte_t'{8'hC2, 1'b0, 1'b0});
    reset_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_nwr", obs_q.size(), 0);
    send_byte(byte_t'{8'hEE, 1'b0, 1'b0});
    send_byte(byte_t'{8'hD0, 1'b1, 1'b0});
    send_byte(byte_t'{8'hD1, 1'b0, 1'b0});
    send_byte(byte_t'{8'hD2, 1'b0, 1'b0});
    send_byte(byte_t'{8'hD3, 1'b0, 1'b1});
    drain();
    check("midrst_after_nwr", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      check("midrst_after_addr", 32'(obs_q[0].addr), 0);
      check("midrst_after_data", obs_q[0].data, 32'hD3D2D1D0);
      check("midrst_after_be", 32'(obs_q[0].be), 32'h0000000F);
    end
    check("midrst_after_done", done_cnt, 1);

    // Randomized packets with random valid gaps against the reference model.
    run_random(1'b0, 10, 14);
    run_random(1'b0, 10, 14);
    run_random(1'b1, 8, 24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
